// File: rtl/ex_muldiv_pkg.sv
// Shared operator/category codes and divider state encoding for the ex_muldiv execute stage.
package ex_muldiv_pkg;

  localparam int OP_WIDTH  = 8;
  localparam int CAT_WIDTH = 3;

  typedef logic [OP_WIDTH-1:0]  alu_operator_t;
  typedef logic [CAT_WIDTH-1:0] alu_category_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam alu_operator_t OPERATOR_NOP   = 8'h00;
  localparam alu_operator_t OPERATOR_AND   = 8'h24;
  localparam alu_operator_t OPERATOR_OR    = 8'h25;
  localparam alu_operator_t OPERATOR_XOR   = 8'h26;
  localparam alu_operator_t OPERATOR_NOR   = 8'h27;
  localparam alu_operator_t OPERATOR_SLL   = 8'h7C;
  localparam alu_operator_t OPERATOR_SRL   = 8'h02;
  localparam alu_operator_t OPERATOR_SRA   = 8'h03;
  localparam alu_operator_t OPERATOR_MFHI  = 8'h10;
  localparam alu_operator_t OPERATOR_MTHI  = 8'h11;
  localparam alu_operator_t OPERATOR_MFLO  = 8'h12;
  localparam alu_operator_t OPERATOR_MTLO  = 8'h13;
  localparam alu_operator_t OPERATOR_MULT  = 8'h18;
  localparam alu_operator_t OPERATOR_MULTU = 8'h19;
  localparam alu_operator_t OPERATOR_DIV   = 8'h1A;
  localparam alu_operator_t OPERATOR_DIVU  = 8'h1B;

  localparam alu_category_t CATEGORY_NOP   = 3'd0;
  localparam alu_category_t CATEGORY_LOGIC = 3'd1;
  localparam alu_category_t CATEGORY_SHIFT = 3'd2;
  localparam alu_category_t CATEGORY_MOVE  = 3'd3;
  localparam alu_category_t CATEGORY_ARITH = 3'd4;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/ex_muldiv_divider.sv
// Iterative restoring divider: one quotient bit per BUSY cycle, signs applied on the way out.
module ex_divider
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  annul,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  div_state_t state, state_next;
  logic [CNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] quo, rem, den;
  logic                  neg_quo, neg_rem;
  logic                  num_neg, den_neg;
  logic [DATA_WIDTH-1:0] num_mag, den_mag;
  logic [DATA_WIDTH:0]   trial;
  logic                  fits;

  assign num_neg = signed_mode & dividend[DATA_WIDTH-1];
  assign den_neg = signed_mode & divisor[DATA_WIDTH-1];
  assign num_mag = num_neg ? -dividend : dividend;
  assign den_mag = den_neg ? -divisor : divisor;
  // Dividend bits stream out of quo's MSB while quotient bits enter at its LSB.
  assign trial   = {rem, quo[DATA_WIDTH-1]};
  assign fits    = trial >= {1'b0, den};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = DISABLE;
    done       = DISABLE;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          busy       = ENABLE;
          state_next = (divisor == '0) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (annul) begin
          state_next = DIV_IDLE;
        end else begin
          busy = ENABLE;
          if (count == CNT_WIDTH'(DATA_WIDTH-1)) state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done       = !annul;
        state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      quo     <= '0;
      rem     <= '0;
      den     <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      count <= '0;
      if (divisor == '0) begin
        quo     <= '1;
        rem     <= dividend;
        den     <= '0;
        neg_quo <= 1'b0;
        neg_rem <= 1'b0;
      end else begin
        quo     <= num_mag;
        rem     <= '0;
        den     <= den_mag;
        neg_quo <= num_neg ^ den_neg;
        neg_rem <= num_neg;
      end
    end else if (state == DIV_BUSY) begin
      count <= count + CNT_WIDTH'(1);
      quo   <= {quo[DATA_WIDTH-2:0], fits};
      rem   <= fits ? (trial[DATA_WIDTH-1:0] - den) : trial[DATA_WIDTH-1:0];
    end
  end

  assign quotient  = neg_quo ? -quo : quo;
  assign remainder = neg_rem ? -rem : rem;

endmodule

// File: rtl/ex_muldiv.sv
// MIPS execute stage with HI/LO registers and an iterative divider that stalls upstream.
// Define EX_MULDIV_MUL_EN to add single-cycle MULT/MULTU into HI/LO.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  alu_operator_t         operator,
  input  alu_category_t         category,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [ADDR_WIDTH-1:0] input_write_addr,
  input  logic                  input_write_enable,
  input  logic                  annul,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  stall_request,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  logic                   is_div, is_mthi, is_mtlo, no_write;
  logic                   div_busy, div_done;
  logic [DATA_WIDTH-1:0]  div_quotient, div_remainder, result;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic signed [DATA_WIDTH-1:0] operand2_signed;

  assign is_div  = (category == CATEGORY_ARITH) &&
                   (operator == OPERATOR_DIV || operator == OPERATOR_DIVU);
  assign is_mthi = (category == CATEGORY_MOVE) && (operator == OPERATOR_MTHI);
  assign is_mtlo = (category == CATEGORY_MOVE) && (operator == OPERATOR_MTLO);
  assign shamt           = operand1[SHAMT_WIDTH-1:0];
  assign operand2_signed = operand2;

`ifdef EX_MULDIV_MUL_EN
  logic                    is_mul, mul_signed;
  logic [2*DATA_WIDTH-1:0] mul_a, mul_b, product;
  assign is_mul     = (category == CATEGORY_ARITH) &&
                      (operator == OPERATOR_MULT || operator == OPERATOR_MULTU);
  assign mul_signed = (operator == OPERATOR_MULT);
  // Sign-extending to the full product width makes one unsigned multiply serve both forms.
  assign mul_a   = {{DATA_WIDTH{mul_signed & operand1[DATA_WIDTH-1]}}, operand1};
  assign mul_b   = {{DATA_WIDTH{mul_signed & operand2[DATA_WIDTH-1]}}, operand2};
  assign product = mul_a * mul_b;
  assign no_write = is_div | is_mthi | is_mtlo | is_mul;
`else
  assign no_write = is_div | is_mthi | is_mtlo;
`endif

  ex_divider #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (SHAMT_WIDTH)
  ) u_divider (
    .clock      (clock),
    .reset      (reset),
    .start      (is_div),
    .signed_mode(operator == OPERATOR_DIV),
    .dividend   (operand1),
    .divisor    (operand2),
    .annul      (annul),
    .busy       (div_busy),
    .done       (div_done),
    .quotient   (div_quotient),
    .remainder  (div_remainder)
  );

  always_comb begin
    result = '0;
    case (category)
      CATEGORY_LOGIC: begin
        case (operator)
          OPERATOR_OR:  result = operand1 | operand2;
          OPERATOR_AND: result = operand1 & operand2;
          OPERATOR_NOR: result = ~(operand1 | operand2);
          OPERATOR_XOR: result = operand1 ^ operand2;
          default:      result = '0;
        endcase
      end
      CATEGORY_SHIFT: begin
        case (operator)
          OPERATOR_SLL: result = operand2 << shamt;
          OPERATOR_SRL: result = operand2 >> shamt;
          OPERATOR_SRA: result = operand2_signed >>> shamt;
          default:      result = '0;
        endcase
      end
      CATEGORY_MOVE: begin
        case (operator)
          OPERATOR_MFHI: result = hi;
          OPERATOR_MFLO: result = lo;
          default:       result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign write_data    = reset ? '0 : result;
  assign write_addr    = reset ? '0 : input_write_addr;
  assign write_enable  = !reset && input_write_enable && !no_write;
  assign stall_request = !reset && div_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (div_done) begin
      hi <= div_remainder;
      lo <= div_quotient;
    end
`ifdef EX_MULDIV_MUL_EN
    else if (is_mul) begin
      hi <= product[2*DATA_WIDTH-1:DATA_WIDTH];
      lo <= product[DATA_WIDTH-1:0];
    end
`endif
    else begin
      if (is_mthi) hi <= operand1;
      if (is_mtlo) lo <= operand1;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: driver predicts each instruction's retire record, monitor checks it.
`timescale 1ns/1ps
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  alu_operator_t operator = OPERATOR_NOP;
  alu_category_t category = CATEGORY_NOP;
  logic [DW-1:0] operand1 = '0, operand2 = '0;
  logic [AW-1:0] input_write_addr = '0;
  logic          input_write_enable = 1'b0;
  logic          annul = 1'b0;
  logic [AW-1:0] write_addr;
  logic          write_enable;
  logic [DW-1:0] write_data, hi, lo;
  logic          stall_request;

  always #5 clock = ~clock;

  ex_muldiv #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .operator(operator), .category(category),
    .operand1(operand1), .operand2(operand2), .input_write_addr(input_write_addr),
    .input_write_enable(input_write_enable), .annul(annul), .write_addr(write_addr),
    .write_enable(write_enable), .write_data(write_data), .stall_request(stall_request),
    .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [DW-1:0] wd;
    bit            chk_wd;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    int            stall;
  } exp_t;

  exp_t          sb[$];
  exp_t          cur;
  int            checks = 0;
  int            errors = 0;
  int            stall_seen = 0;
  bit            active = 1'b0;
  logic [DW-1:0] m_hi = '0, m_lo = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every non-stalled cycle retires exactly one instruction.
  always @(negedge clock) begin
    if (reset) begin
      stall_seen = 0;
      check("rst_stall", 64'(stall_request), 64'(0));
      check("rst_we", 64'(write_enable), 64'(0));
      check("rst_wd", 64'(write_data), 64'(0));
      check("rst_hi", 64'(hi), 64'(0));
      check("rst_lo", 64'(lo), 64'(0));
    end else if (active) begin
      if (stall_request) begin
        stall_seen++;
      end else begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire got retire want none at %0t", $time);
        end else begin
          cur = sb.pop_front();
          check("stall_cycles", 64'(stall_seen), 64'(cur.stall));
          check("write_enable", 64'(write_enable), 64'(cur.we));
          check("write_addr", 64'(write_addr), 64'(cur.wa));
          check("hi", 64'(hi), 64'(cur.hi));
          check("lo", 64'(lo), 64'(cur.lo));
          if (cur.chk_wd) check("write_data", 64'(write_data), 64'(cur.wd));
        end
        stall_seen = 0;
      end
    end
  end

  // Reference model: architectural result of one instruction, straight from the ISA rules.
  task automatic predict(alu_operator_t op, alu_category_t cat, logic [DW-1:0] a,
                         logic [DW-1:0] b, logic [AW-1:0] wa, logic we);
    exp_t          e;
    logic [DW-1:0] ones = '1;
    logic [DW-1:0] nhi = m_hi, nlo = m_lo;
    int unsigned   sh = a[4:0];
    longint        sa, sbv, q, r;
    e.hi = m_hi; e.lo = m_lo; e.wa = wa; e.we = we; e.wd = '0; e.chk_wd = 1'b1; e.stall = 0;
    case (cat)
      CATEGORY_LOGIC: begin
        if (op == OPERATOR_OR)       e.wd = a | b;
        else if (op == OPERATOR_AND) e.wd = a & b;
        else if (op == OPERATOR_NOR) e.wd = ~(a | b);
        else if (op == OPERATOR_XOR) e.wd = a ^ b;
      end
      CATEGORY_SHIFT: begin
        if (op == OPERATOR_SLL)      e.wd = b << sh;
        else if (op == OPERATOR_SRL) e.wd = b >> sh;
        else if (op == OPERATOR_SRA) e.wd = (b >> sh) | (b[DW-1] ? ~(ones >> sh) : '0);
      end
      CATEGORY_MOVE: begin
        if (op == OPERATOR_MFHI)      e.wd = m_hi;
        else if (op == OPERATOR_MFLO) e.wd = m_lo;
        else if (op == OPERATOR_MTHI) begin e.we = 1'b0; e.chk_wd = 1'b0; nhi = a; end
        else if (op == OPERATOR_MTLO) begin e.we = 1'b0; e.chk_wd = 1'b0; nlo = a; end
      end
      CATEGORY_ARITH: begin
        if (op == OPERATOR_DIV || op == OPERATOR_DIVU) begin
          e.we = 1'b0; e.chk_wd = 1'b0;
          if (b == '0) begin
            e.stall = 1; nlo = '1; nhi = a;
          end else begin
            e.stall = DW + 1;
            if (op == OPERATOR_DIV) begin
              sa = longint'($signed(a)); sbv = longint'($signed(b));
              q = sa / sbv; r = sa % sbv;
              nlo = q[DW-1:0]; nhi = r[DW-1:0];
            end else begin
              nlo = a / b; nhi = a % b;
            end
          end
        end
`ifdef EX_MULDIV_MUL_EN
        else if (op == OPERATOR_MULT || op == OPERATOR_MULTU) begin
          e.we = 1'b0; e.chk_wd = 1'b0;
          if (op == OPERATOR_MULT) q = longint'($signed(a)) * longint'($signed(b));
          else                     q = longint'({32'h0, a}) * longint'({32'h0, b});
          nhi = q[2*DW-1:DW]; nlo = q[DW-1:0];
        end
`endif
      end
      default: e.wd = '0;
    endcase
    sb.push_back(e);
    m_hi = nhi;
    m_lo = nlo;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the instruction retires.
  task automatic issue(alu_operator_t op, alu_category_t cat, logic [DW-1:0] a,
                       logic [DW-1:0] b, logic [AW-1:0] wa, logic we);
    bit got = 1'b0;
    predict(op, cat, a, b, wa, we);
    operator = op; category = cat; operand1 = a; operand2 = b;
    input_write_addr = wa; input_write_enable = we;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (!stall_request) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout got stalled want retire op %h", op);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue_annul(logic [DW-1:0] a, logic [DW-1:0] b, int at);
    exp_t e;
    e.wd = '0; e.chk_wd = 1'b0; e.we = 1'b0; e.wa = 5'd3; e.hi = m_hi; e.lo = m_lo; e.stall = at;
    sb.push_back(e);
    operator = OPERATOR_DIV; category = CATEGORY_ARITH; operand1 = a; operand2 = b;
    input_write_addr = 5'd3; input_write_enable = 1'b1;
    repeat (at) @(posedge clock);
    #1 annul = 1'b1;
    @(posedge clock);
    #1 annul = 1'b0;
  endtask

  task automatic reset_mid_div();
    operator = OPERATOR_DIV; category = CATEGORY_ARITH; operand1 = 32'd1000; operand2 = 32'd7;
    input_write_addr = 5'd4; input_write_enable = 1'b1;
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_stall", 64'(stall_request), 64'(0));
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  alu_operator_t logic_ops[4] = '{OPERATOR_OR, OPERATOR_AND, OPERATOR_NOR, OPERATOR_XOR};
  alu_operator_t shift_ops[3] = '{OPERATOR_SLL, OPERATOR_SRL, OPERATOR_SRA};

  initial begin
    logic [DW-1:0] a, b;
    logic [AW-1:0] wa;
    logic          we;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    active = 1'b1;

    issue(OPERATOR_SRA, CATEGORY_SHIFT, 32'd4, 32'h80000000, 5'd1, 1'b1);
    issue(OPERATOR_DIV, CATEGORY_ARITH, 32'd7, -32'sd2, 5'd2, 1'b1);
    issue(OPERATOR_MFLO, CATEGORY_MOVE, 32'd0, 32'd0, 5'd5, 1'b1);
    issue(OPERATOR_MFHI, CATEGORY_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
    issue(OPERATOR_DIVU, CATEGORY_ARITH, 32'h12345678, 32'd0, 5'd7, 1'b1);
    issue(OPERATOR_MFHI, CATEGORY_MOVE, 32'd0, 32'd0, 5'd8, 1'b1);
    issue(OPERATOR_DIV, CATEGORY_ARITH, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1'b1);
    issue(OPERATOR_MFLO, CATEGORY_MOVE, 32'd0, 32'd0, 5'd10, 1'b1);
    issue(OPERATOR_MTHI, CATEGORY_MOVE, 32'hAA, 32'd0, 5'd11, 1'b1);
    issue(OPERATOR_MTLO, CATEGORY_MOVE, 32'h55, 32'd0, 5'd12, 1'b1);
    issue_annul(32'd1000, 32'd3, 10);
    issue(OPERATOR_MFHI, CATEGORY_MOVE, 32'd0, 32'd0, 5'd13, 1'b1);
    issue(OPERATOR_MFLO, CATEGORY_MOVE, 32'd0, 32'd0, 5'd14, 1'b1);

    for (int n = 0; n < 80; n++) begin
      a = $urandom; b = $urandom; wa = AW'($urandom_range(0, 31)); we = 1'($urandom);
      case ($urandom_range(0, 7))
        0: issue(logic_ops[$urandom_range(0, 3)], CATEGORY_LOGIC, a, b, wa, we);
        1: issue(shift_ops[$urandom_range(0, 2)], CATEGORY_SHIFT, a, b, wa, we);
        2: issue($urandom_range(0, 1) ? OPERATOR_MFHI : OPERATOR_MFLO, CATEGORY_MOVE, a, b, wa, we);
        3: issue($urandom_range(0, 1) ? OPERATOR_MTHI : OPERATOR_MTLO, CATEGORY_MOVE, a, b, wa, we);
        4, 5: begin
          case ($urandom_range(0, 3))
            0: b = '0;
            1: b = b >> $urandom_range(0, 31);
            2: b = -DW'($urandom_range(1, 9));
            default: ;
          endcase
          issue($urandom_range(0, 1) ? OPERATOR_DIV : OPERATOR_DIVU, CATEGORY_ARITH, a, b, wa, we);
        end
        6: issue($urandom_range(0, 1) ? OPERATOR_MULT : OPERATOR_MULTU, CATEGORY_ARITH, a, b, wa, we);
        default: issue(OPERATOR_OR, $urandom_range(0, 1) ? CATEGORY_NOP : 3'd7, a, b, wa, we);
      endcase
    end

    issue(OPERATOR_MTHI, CATEGORY_MOVE, 32'h1234, 32'd0, 5'd15, 1'b1);
    issue(OPERATOR_MTLO, CATEGORY_MOVE, 32'h5678, 32'd0, 5'd16, 1'b1);
    reset_mid_div();
    issue(OPERATOR_MFLO, CATEGORY_MOVE, 32'd0, 32'd0, 5'd17, 1'b1);
    issue(OPERATOR_MFHI, CATEGORY_MOVE, 32'd0, 32'd0, 5'd18, 1'b1);

    active = 1'b0;
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised next-generation execute stage for the MIPS pipeline, sitting between id_ex and ex_mem.
- Keeps single-cycle logic/shift paths, generalised to DATA_WIDTH.
- Adds architectural HI/LO registers (MFHI/MFLO/MTHI/MTLO) and an iterative signed/unsigned divider that stalls the pipeline through stall_request.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, >= 8.
- SHAMT_WIDTH, 5, shift-amount bits taken from operand1; equals log2(DATA_WIDTH).
- ADDR_WIDTH, 5, register-file address width.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- operator  in  ALU_OPERATOR_BUS  operation code.
- category  in  ALU_CATEGORY_BUS  result category (LOGIC, SHIFT, MOVE, ARITH).
- operand1  in  DATA_WIDTH  source A / shift amount / dividend.
- operand2  in  DATA_WIDTH  source B / shifted value / divisor.
- input_write_addr  in  ADDR_WIDTH  destination register.
- input_write_enable  in  1  destination write request.
- annul  in  1  flush from a later stage; cancels an in-flight divide.
- write_addr  out  ADDR_WIDTH  passed-through destination.
- write_enable  out  1  passed-through write enable.
- write_data  out  DATA_WIDTH  result.
- stall_request  out  1  holds the upstream pipeline while the divider is busy.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (async): hi=lo=0, FSM=IDLE, iteration count=0. While reset is high, all combinational outputs are 0.
- LOGIC ops OR/AND/NOR/XOR and SHIFT ops SLL/SRL/SRA: combinational, same cycle.
  - Shift amount is operand1[SHAMT_WIDTH-1:0].
  - SRA sign-fills from operand2[DATA_WIDTH-1].
- MOVE category:
  - MFHI/MFLO: write_data = hi/lo, combinational.
  - MTHI/MTLO: hi/lo <= operand1 at the clock edge. write_enable output is 0.
- Pass-through: write_addr/write_enable track the inputs. Exceptions: DIV/DIVU and MT* force write_enable=0.
- Unknown category: write_data=0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE + DIV/DIVU with divisor!=0 (cycle 0): stall_request=1; latch |dividend|, |divisor| (plain values for DIVU) and result signs; count=0; go to BUSY.
  - BUSY (cycles 1..DATA_WIDTH): restoring divide, one quotient bit per cycle; stall_request=1. At count=DATA_WIDTH-1, go to DONE.
  - DONE (cycle DATA_WIDTH+1): stall_request=0; at the edge, lo<=quotient and hi<=remainder; go to IDLE.
  - Total stall is DATA_WIDTH+1 cycles. The instruction leaves EX at the end of the DONE cycle.
- Sign rules: quotient negated when the operand signs differ; remainder takes the dividend's sign. MIN/-1 gives lo=MIN, hi=0 with no special case.
- Divide by zero: IDLE goes straight to DONE, so stall lasts 1 cycle. Result is lo=all ones, hi=operand1.
- annul high in BUSY or DONE: go to IDLE next edge, no hi/lo write, stall_request drops combinationally in the same cycle. annul in IDLE has no effect.
- Upstream must hold the operator/operands stable while stall_request=1. The FSM does not re-issue while in DONE.
- Reset mid-divide: immediate return to IDLE; hi/lo cleared.

Optional Feature:
- Macro EX_MULDIV_MUL_EN.
- Defined: MULT/MULTU accepted in the ARITH category. A single-cycle full product of 2*DATA_WIDTH bits is formed; hi<=upper half and lo<=lower half at the edge. No stall, write_enable=0.
- Undefined: MULT/MULTU fall into the default path (write_data=0, no hi/lo change); the multiplier is not synthesised.

Decomposition:
- macro.v holds:
  - OPERATOR_* codes, including new DIV, DIVU, MULT, MULTU, MFHI, MFLO, MTHI, MTLO.
  - CATEGORY_MOVE and CATEGORY_ARITH.
  - Divider state encodings DIV_IDLE/DIV_BUSY/DIV_DONE.
  - ENABLE/DISABLE.
- Sub-module ex_divider contains the FSM, counter, sign handling, annul and start/done handshake. It exposes start, signed_mode, dividend, divisor, annul, busy, done, quotient, remainder. ex_muldiv owns hi/lo and the result mux.

Test Plan:
- Reset asserted mid-BUSY -> hi=lo=0, stall_request=0 immediately, FSM IDLE.
- SRA, operand2=0x80000000, operand1=4 -> write_data=0xF8000000 same cycle.
- DIV 7 / -2 -> stall high exactly 33 cycles, then lo=0xFFFFFFFD, hi=0x00000001.
- DIVU 0x12345678 / 0 -> 1 stall cycle, lo=0xFFFFFFFF, hi=0x12345678.
- DIV 0x80000000 / -1 -> lo=0x80000000, hi=0; then MFLO -> write_data=0x80000000.
- DIV started, annul at cycle 10 -> stall drops that cycle; hi/lo unchanged from a prior MTHI 0xAA / MTLO 0x55.
